div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider in the execute stage. It serves the MIPS DIV/DIVU instructions.
- The execute stage converts the ALU_DIV/ALU_DIVU control codes from the ALU decoder into a start pulse and a signed flag. It then stalls the pipeline while this block iterates.
- Quotient and remainder go to the HI/LO write path: quotient to LO, remainder to HI.
- Implementation: radix-2 restoring divide on magnitudes, with sign correction at the end.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is verified.
- CNT_W, 5, iteration counter width; log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  request a divide. Sampled only in IDLE or DONE.
- div_signed  input  1  1 = DIV (two's complement), 0 = DIVU. Sampled with start.
- annul  input  1  abort the in-flight divide (exception/flush).
- dividend  input  WIDTH  rs operand. Sampled with start.
- divisor  input  WIDTH  rt operand. Sampled with start.
- busy  output  1  pipeline stall request.
- ready  output  1  results valid this cycle. One-cycle pulse.
- quotient  output  WIDTH  goes to LO.
- remainder  output  WIDTH  goes to HI.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on resetn.
- On resetn low:
  - state = IDLE; counter = 0.
  - quotient = 0, remainder = 0.
  - ready = 0, busy = 0.
  - All internal working registers = 0.
  - Asynchronous reset aborts any divide in progress, with no ready pulse.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Without start, stay in IDLE.
  - With start (and annul = 0), latch the following and go to BUSY:
    - |dividend| and |divisor| (magnitudes when div_signed = 1, raw values otherwise);
    - quotient-negate flag = div_signed & (sign of dividend XOR sign of divisor);
    - remainder-negate flag = div_signed & sign of dividend;
    - divisor-zero flag.
  - Counter is cleared to 0 on entry to BUSY.
- BUSY:
  - One restoring iteration per cycle. Shift {rem, quo} left by 1, trial-subtract the divisor magnitude, and keep the difference if non-negative. Quotient bit = 1 in that case.
  - The partial remainder is WIDTH+1 bits wide to hold the carry.
  - Leave BUSY for DONE on the edge where counter = WIDTH-1. Otherwise increment the counter.
- DONE:
  - ready = 1 for exactly this cycle.
  - quotient/remainder outputs show the sign-corrected results.
  - start in DONE is accepted exactly as in IDLE (back-to-back divide). Otherwise go to IDLE.
- Sign correction:
  - Negate the quotient if its flag is set.
  - Negate the remainder if its flag is set, so the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0. Natural wrap, no trap.
- Divisor zero:
  - Same 32-cycle latency.
  - quotient = 0xFFFFFFFF, remainder = original dividend. No sign correction applies.
- Latency: with start high in cycle 0 (accepted), busy = 1 in cycles 0..32 and ready = 1 in cycle 33.
- busy:
  - Combinational: (start & ~annul & state in {IDLE, DONE}) | state == BUSY.
  - busy = 0 in the DONE cycle unless a new start is accepted in that cycle.
- Output holding: quotient/remainder outputs hold their last values after DONE until the next DONE. They are not updated during BUSY.
- annul:
  - annul in BUSY: go to IDLE on the next edge. No ready pulse; outputs unchanged.
  - annul with start in the same cycle: start is ignored.
  - annul in DONE: the ready pulse still occurs. Suppressing it is the consumer's job.
- start while BUSY: ignored. The pipeline is stalled, so this is a protocol violation, but the block must not corrupt the divide in progress.

Test Plan:
- Signed 100 / 7 → ready in cycle 33; quotient 0x0000000E, remainder 0x00000002. busy high in cycles 0..32.
- Signed 0xFFFFFFF9 (-7) / 2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Then 7 / 0xFFFFFFFE (-2) → quotient 0xFFFFFFFD, remainder 0x00000001.
- Unsigned 0xFFFFFFFF / 2 → quotient 0x7FFFFFFF, remainder 1. Then signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divisor 0, dividend 0x12345678, signed and unsigned → quotient 0xFFFFFFFF, remainder 0x12345678, ready in cycle 33.
- Back-to-back: start reasserted in the DONE cycle with 50 / 5 → first result ready in cycle 33, second ready in cycle 66 (quotient 10, remainder 0). busy stays high from cycle 34 to cycle 65.
- annul in cycle 10 → no ready pulse, busy low from cycle 11, outputs keep their prior values.
- resetn low in cycle 15 → all outputs 0 immediately. A fresh start after release completes normally.

Source files
------------

// File: rtl/div_unit_if.sv
// Divider request/result bundle between the execute stage and div_unit.
// The execute stage drives the master side; the divider owns the slave side.
interface div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             div_signed;
    logic             annul;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, div_signed, annul, dividend, divisor,
        input  busy, ready, quotient, remainder
    );

    modport slave (
        input  start, div_signed, annul, dividend, divisor,
        output busy, ready, quotient, remainder
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// It divides magnitudes, then sign-corrects: quotient goes to LO, remainder to HI.
module div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic       clk,
    input  logic       resetn,
    div_unit_if.slave  bus_io
);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             dz_q;
    logic             ready_q;

    logic             accept;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign accept = bus_io.start & ~bus_io.annul & (state_q == StIdle || state_q == StDone);

    assign bus_io.busy      = accept | (state_q == StBusy);
    assign bus_io.ready     = ready_q;
    assign bus_io.quotient  = quotient_q;
    assign bus_io.remainder = remainder_q;

    always_comb begin
        dvd_abs = (bus_io.div_signed & bus_io.dividend[WIDTH-1]) ? -bus_io.dividend
                                                                 : bus_io.dividend;
        dvs_abs = (bus_io.div_signed & bus_io.divisor[WIDTH-1]) ? -bus_io.divisor
                                                                : bus_io.divisor;
    end

    // Partial remainder stays below the divisor, so the WIDTH+1-bit trial
    // difference only needs its top bit as the borrow.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nxt = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        q_fix   = dz_q ? '1 : (qneg_q ? -quo_nxt : quo_nxt);
        // With a zero divisor rem_nxt is |dividend|, so this restores the original dividend.
        r_fix   = rneg_q ? -rem_nxt : rem_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (accept) begin
                state_q <= StBusy;
                cnt_q   <= '0;
                rem_q   <= '0;
                quo_q   <= dvd_abs;
                dvs_q   <= dvs_abs;
                qneg_q  <= bus_io.div_signed &
                           (bus_io.dividend[WIDTH-1] ^ bus_io.divisor[WIDTH-1]);
                rneg_q  <= bus_io.div_signed & bus_io.dividend[WIDTH-1];
                dz_q    <= (bus_io.divisor == '0);
            end else begin
                case (state_q)
                    StBusy: begin
                        if (bus_io.annul) begin
                            state_q <= StIdle;
                        end else begin
                            rem_q <= rem_nxt;
                            quo_q <= quo_nxt;
                            if (cnt_q == LastCnt) begin
                                state_q     <= StDone;
                                ready_q     <= 1'b1;
                                quotient_q  <= q_fix;
                                remainder_q <= r_fix;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table plus hand-written
// sequences for back-to-back, start-while-busy, annul and mid-divide reset.
module tb_div_unit;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        string       nm;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, sample at the following negedge.
    task automatic step(input logic st, input logic sg, input logic an,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic bz, output logic rd,
                        output logic [31:0] gq, output logic [31:0] gr);
        bus.start      = st;
        bus.div_signed = sg;
        bus.annul      = an;
        bus.dividend   = a;
        bus.divisor    = b;
        @(negedge clk);
        bz = bus.busy;
        rd = bus.ready;
        gq = bus.quotient;
        gr = bus.remainder;
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input string nm, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] q, input logic [31:0] r);
        logic bz, rd;
        logic [31:0] oq, or_, gq, gr;
        int rdy_c, bad;
        rdy_c = -1;
        bad   = 0;
        gq    = '0;
        gr    = '0;
        for (int c = 0; c < 40 && rdy_c < 0; c++) begin
            step(c == 0, sg, 1'b0, a, b, bz, rd, oq, or_);
            if (bz !== (c <= 32)) bad++;
            if (rd === 1'b1) begin
                rdy_c = c;
                gq    = oq;
                gr    = or_;
            end
        end
        chk({nm, " ready_cycle"}, 32'(rdy_c), 32'd33);
        chk({nm, " busy_bad_cycles"}, 32'(bad), 32'd0);
        chk({nm, " quotient"}, gq, q);
        chk({nm, " remainder"}, gr, r);
    endtask

    initial begin
        logic bz, rd;
        logic [31:0] oq, or_;
        logic [31:0] q1, r1, q2, r2, hq, hr;
        int bad, n_rdy, c1, c2;

        checks = 0;
        errors = 0;

        vecs[0] = '{1'b1, 32'd100,       32'd7,         32'h0000000E, 32'h00000002, "s100_7"};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD, 32'hFFFFFFFF, "sm7_2"};
        vecs[2] = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD, 32'h00000001, "s7_m2"};
        vecs[3] = '{1'b0, 32'hFFFFFFFF,  32'd2,         32'h7FFFFFFF, 32'h00000001, "uffff_2"};
        vecs[4] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 32'h00000000, "smin_m1"};
        vecs[5] = '{1'b1, 32'h12345678,  32'd0,         32'hFFFFFFFF, 32'h12345678, "sdz"};
        vecs[6] = '{1'b0, 32'h12345678,  32'd0,         32'hFFFFFFFF, 32'h12345678, "udz"};
        vecs[7] = '{1'b1, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF, 32'hFFFFFFF9, "sdz_neg"};
        vecs[8] = '{1'b0, 32'h80000000,  32'd3,         32'h2AAAAAAA, 32'h00000002, "u8000_3"};
        vecs[9] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'h0000000E, 32'hFFFFFFFE, "sm100_m7"};

        resetn         = 1'b0;
        bus.start      = 1'b0;
        bus.div_signed = 1'b0;
        bus.annul      = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        #12;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset ready", 32'(bus.ready), 32'd0);
        chk("reset quotient", bus.quotient, 32'd0);
        chk("reset remainder", bus.remainder, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_div(vecs[i].nm, vecs[i].sg, vecs[i].a, vecs[i].b,
                                  vecs[i].q, vecs[i].r);

        // Back-to-back: second start accepted in the first DONE cycle.
        bad = 0; n_rdy = 0; c1 = -1; c2 = -1;
        q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int c = 0; c < 70; c++) begin
            step(c == 0 || c == 33, 1'b1, 1'b0, (c < 33) ? 32'd100 : 32'd50,
                 (c < 33) ? 32'd7 : 32'd5, bz, rd, oq, or_);
            if (bz !== (c <= 65)) bad++;
            if (rd === 1'b1) begin
                if (n_rdy == 0) begin c1 = c; q1 = oq; r1 = or_; end
                else begin c2 = c; q2 = oq; r2 = or_; end
                n_rdy++;
            end
        end
        chk("b2b ready_count", 32'(n_rdy), 32'd2);
        chk("b2b first_cycle", 32'(c1), 32'd33);
        chk("b2b second_cycle", 32'(c2), 32'd66);
        chk("b2b busy_bad_cycles", 32'(bad), 32'd0);
        chk("b2b q1", q1, 32'h0000000E);
        chk("b2b r1", r1, 32'h00000002);
        chk("b2b q2", q2, 32'd10);
        chk("b2b r2", r2, 32'd0);

        // start while BUSY must not disturb the divide in progress.
        bad = 0; c1 = -1; q1 = '0; r1 = '0;
        for (int c = 0; c < 40; c++) begin
            step(c == 0 || c == 5, 1'b1, 1'b0, (c == 0) ? 32'hFFFFFF9C : 32'd1,
                 (c == 0) ? 32'd7 : 32'd1, bz, rd, oq, or_);
            if (bz !== (c <= 32)) bad++;
            if (rd === 1'b1 && c1 < 0) begin c1 = c; q1 = oq; r1 = or_; end
        end
        chk("swb ready_cycle", 32'(c1), 32'd33);
        chk("swb busy_bad_cycles", 32'(bad), 32'd0);
        chk("swb quotient", q1, 32'hFFFFFFF2);
        chk("swb remainder", r1, 32'hFFFFFFFE);

        // annul in cycle 10, then start+annul together in cycle 20 (ignored).
        bad = 0; n_rdy = 0; hq = '0; hr = '0;
        for (int c = 0; c < 40; c++) begin
            step(c == 0 || c == 20, 1'b0, c == 10 || c == 20, 32'd1000, 32'd3,
                 bz, rd, oq, or_);
            if (bz !== (c <= 10)) bad++;
            if (rd === 1'b1) n_rdy++;
            hq = oq;
            hr = or_;
        end
        chk("annul ready_count", 32'(n_rdy), 32'd0);
        chk("annul busy_bad_cycles", 32'(bad), 32'd0);
        chk("annul quotient_held", hq, 32'hFFFFFFF2);
        chk("annul remainder_held", hr, 32'hFFFFFFFE);

        // annul in DONE: the ready pulse still happens.
        bad = 0; c1 = -1; q1 = '0; r1 = '0;
        for (int c = 0; c < 36; c++) begin
            step(c == 0, 1'b0, c == 33, 32'd1000, 32'd3, bz, rd, oq, or_);
            if (bz !== (c <= 32)) bad++;
            if (rd === 1'b1 && c1 < 0) begin c1 = c; q1 = oq; r1 = or_; end
        end
        chk("annul_done ready_cycle", 32'(c1), 32'd33);
        chk("annul_done busy_bad_cycles", 32'(bad), 32'd0);
        chk("annul_done quotient", q1, 32'd333);
        chk("annul_done remainder", r1, 32'd1);

        // Asynchronous reset in cycle 15 of a divide.
        for (int c = 0; c < 15; c++) step(c == 0, 1'b1, 1'b0, 32'd100, 32'd7, bz, rd, oq, or_);
        resetn = 1'b0;
        #2;
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset ready", 32'(bus.ready), 32'd0);
        chk("midreset quotient", bus.quotient, 32'd0);
        chk("midreset remainder", bus.remainder, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        n_rdy = 0;
        for (int c = 0; c < 40; c++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, bz, rd, oq, or_);
            if (rd === 1'b1) n_rdy++;
        end
        chk("midreset no_ready", 32'(n_rdy), 32'd0);
        run_div("post_reset", 1'b1, 32'd100, 32'd7, 32'h0000000E, 32'h00000002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
